cory_pack4: RTL

- Gathers four independent valid/ready lanes (z0..z3) into one packed output word {z3,z2,z1,z0}.
- It is the inverse of the four-way unpack path: it sits where separately produced fields must be rejoined into one transaction.
- Each lane has its own one-entry holding slot, so lanes may arrive in any order and on any cycle.
- The output fires only when all four slots are filled.

---
 rtl/cory_pack4.sv | 62 ++++++
 1 files changed

// File: rtl/cory_pack4.sv
// cory_pack4: joins four independent valid/ready lanes into one packed word {z3,z2,z1,z0}.
// Each lane has a one-entry slot; the word is valid once all four slots are full.
module cory_pack4 #(
    parameter int N  = 8,
    parameter int Z0 = N,
    parameter int Z1 = N,
    parameter int Z2 = N,
    parameter int Z3 = N
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_z0_v,
    input  logic [Z0-1:0]          i_z0_d,
    output logic                   o_z0_r,
    input  logic                   i_z1_v,
    input  logic [Z1-1:0]          i_z1_d,
    output logic                   o_z1_r,
    input  logic                   i_z2_v,
    input  logic [Z2-1:0]          i_z2_d,
    output logic                   o_z2_r,
    input  logic                   i_z3_v,
    input  logic [Z3-1:0]          i_z3_d,
    output logic                   o_z3_r,
    output logic                   o_a_v,
    output logic [Z0+Z1+Z2+Z3-1:0] o_a_d,
    input  logic                   i_a_r,
    output logic [3:0]             o_full
);
    logic [3:0] full, cap;
    logic fire;
    logic [Z0-1:0] slot0;
    logic [Z1-1:0] slot1;
    logic [Z2-1:0] slot2;
    logic [Z3-1:0] slot3;

    assign o_a_v  = &full;
    assign fire   = o_a_v & i_a_r;
    // ready looks through i_a_r so a draining slot can refill on the same edge
    assign o_z0_r = ~reset & (~full[0] | fire);
    assign o_z1_r = ~reset & (~full[1] | fire);
    assign o_z2_r = ~reset & (~full[2] | fire);
    assign o_z3_r = ~reset & (~full[3] | fire);
    assign cap    = {i_z3_v & o_z3_r, i_z2_v & o_z2_r, i_z1_v & o_z1_r, i_z0_v & o_z0_r};
    assign o_a_d  = {slot3, slot2, slot1, slot0};
    assign o_full = full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full  <= '0;
            slot0 <= '0;
            slot1 <= '0;
            slot2 <= '0;
            slot3 <= '0;
        end else begin
            full <= cap | (full & {4{~fire}});
            if (cap[0]) slot0 <= i_z0_d;
            if (cap[1]) slot1 <= i_z1_d;
            if (cap[2]) slot2 <= i_z2_d;
            if (cap[3]) slot3 <= i_z3_d;
        end
    end
endmodule
